// File: rtl/kyber_pkg.sv
// Shared defaults, FSM encoding and residue helpers for the Baby-Kyber engines.
package kyber_pkg;

  localparam int K_DEF  = 2;
  localparam int N_DEF  = 4;
  localparam int Q_DEF  = 17;
  localparam int EW_DEF = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_MAC   = 2'd2;
  localparam logic [1:0] ST_FINAL = 2'd3;

  function automatic int unsigned qhalf(input int unsigned q);
    return (q + 1) / 2;
  endfunction

  function automatic int unsigned mod_q(input int unsigned x, input int unsigned q);
    return x % q;
  endfunction

  // Signed noise sample to its residue in [0,q).
  function automatic int unsigned s2res(input int x, input int q);
    int m;
    m = x % q;
    if (m < 0) m = m + q;
    return unsigned'(m);
  endfunction

endpackage

// File: rtl/kyber_mod_mac.sv
// Combinational modular multiply-accumulate: (acc +/- a*b) mod Q, result in [0,Q).
module kyber_mod_mac
  import kyber_pkg::*;
#(
  parameter int Q  = Q_DEF,
  parameter int CW = $clog2(Q)
) (
  input  logic [CW-1:0] acc_i,
  input  logic [CW-1:0] a_i,
  input  logic [CW-1:0] b_i,
  input  logic          sub_i,
  output logic [CW-1:0] res_o
);

  localparam logic [2*CW-1:0] QP = (2*CW)'(Q);
  localparam logic [CW:0]     QS = (CW+1)'(Q);

  logic [2*CW-1:0] prod;
  logic [CW-1:0]   pm;
  logic [CW:0]     sum;

  // acc < Q and pm < Q, so one conditional subtract finishes the reduction.
  always_comb begin
    prod = {{CW{1'b0}}, a_i} * {{CW{1'b0}}, b_i};
    pm   = CW'(prod % QP);
    if (sub_i) sum = {1'b0, acc_i} + QS - {1'b0, pm};
    else       sum = {1'b0, acc_i} + {1'b0, pm};
    res_o = (sum >= QS) ? CW'(sum - QS) : sum[CW-1:0];
  end

endmodule

// File: rtl/kyber_encrypt_seq.sv
// Sequential Baby-Kyber encryption: u = A^T*r + e1, v = t^T*r + e2 + QHALF*m,
// computed one coefficient product per cycle through a single modular MAC.
module kyber_encrypt_seq
  import kyber_pkg::*;
#(
  parameter int K  = K_DEF,
  parameter int N  = N_DEF,
  parameter int Q  = Q_DEF,
  parameter int CW = $clog2(Q),
  parameter int EW = EW_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  input  logic [K*K*N*CW-1:0]   a_in,
  input  logic [K*N*CW-1:0]     t_in,
  input  logic [K*N*EW-1:0]     r_in,
  input  logic [K*N*EW-1:0]     e1_in,
  input  logic [N*EW-1:0]       e2_in,
  input  logic [N-1:0]          msg,
  output logic [K*N*CW-1:0]     u_out,
  output logic [N*CW-1:0]       v_out
);

  localparam int RW = $clog2(K+1);
  localparam int JW = (K > 1) ? $clog2(K) : 1;
  localparam int NW = (N > 1) ? $clog2(N) : 1;

  localparam logic [RW-1:0] RO_LAST = RW'(K);
  localparam logic [JW-1:0] J_LAST  = JW'(K-1);
  localparam logic [NW-1:0] N_LAST  = NW'(N-1);

  logic [1:0]    state_q, state_d;
  logic [RW-1:0] ro_q, ro_d;
  logic [JW-1:0] j_q, j_d;
  logic [NW-1:0] i_q, i_d, k_q, k_d;
  logic          done_q;

  logic [CW-1:0] a_q   [K][K][N];
  logic [CW-1:0] t_q   [K][N];
  logic [CW-1:0] r_q   [K][N];
  logic [CW-1:0] e1_q  [K][N];
  logic [CW-1:0] e2_q  [N];
  logic [N-1:0]  msg_q;
  logic [CW-1:0] acc_q [K+1][N];

  logic [K*N*CW-1:0] u_q;
  logic [N*CW-1:0]   v_q;

  logic [NW:0]   isum;
  logic          wrap;
  logic [NW-1:0] d_idx;
  logic [CW-1:0] a_op, b_op, acc_op, mac_res;

  // Row K of the accumulator array holds t^T*r; rows 0..K-1 hold A^T*r.
  always_comb begin
    isum   = {1'b0, i_q} + {1'b0, k_q};
    wrap   = (isum >= (NW+1)'(N));
    d_idx  = wrap ? NW'(isum - (NW+1)'(N)) : isum[NW-1:0];
    a_op   = (ro_q == RO_LAST) ? t_q[j_q][i_q] : a_q[j_q][ro_q[JW-1:0]][i_q];
    b_op   = r_q[j_q][k_q];
    acc_op = acc_q[ro_q][d_idx];
  end

  kyber_mod_mac #(.Q(Q), .CW(CW)) u_mac (
    .acc_i (acc_op),
    .a_i   (a_op),
    .b_i   (b_op),
    .sub_i (wrap),
    .res_o (mac_res)
  );

  always_comb begin
    state_d = state_q;
    ro_d    = ro_q;
    j_d     = j_q;
    i_d     = i_q;
    k_d     = k_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d = ST_MAC;
        ro_d = '0; j_d = '0; i_d = '0; k_d = '0;
      end
      ST_MAC: begin
        if (k_q == N_LAST) begin
          k_d = '0;
          if (i_q == N_LAST) begin
            i_d = '0;
            if (j_q == J_LAST) begin
              j_d = '0;
              if (ro_q == RO_LAST) begin
                ro_d    = '0;
                state_d = ST_FINAL;
              end else begin
                ro_d = ro_q + RW'(1);
              end
            end else begin
              j_d = j_q + JW'(1);
            end
          end else begin
            i_d = i_q + NW'(1);
          end
        end else begin
          k_d = k_q + NW'(1);
        end
      end
      ST_FINAL: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ro_q    <= '0;
      j_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      done_q  <= 1'b0;
      u_q     <= '0;
      v_q     <= '0;
      msg_q   <= '0;
      for (int j = 0; j < K; j++)
        for (int i = 0; i < N; i++) begin
          t_q[j][i]  <= '0;
          r_q[j][i]  <= '0;
          e1_q[j][i] <= '0;
          for (int c = 0; c < K; c++) a_q[j][c][i] <= '0;
        end
      for (int i = 0; i < N; i++) e2_q[i] <= '0;
      for (int r = 0; r <= K; r++)
        for (int i = 0; i < N; i++) acc_q[r][i] <= '0;
    end else begin
      state_q <= state_d;
      ro_q    <= ro_d;
      j_q     <= j_d;
      i_q     <= i_d;
      k_q     <= k_d;
      done_q  <= (state_q == ST_FINAL);
      case (state_q)
        ST_LOAD: begin
          msg_q <= msg;
          for (int j = 0; j < K; j++)
            for (int i = 0; i < N; i++) begin
              t_q[j][i]  <= CW'(mod_q(32'(t_in[(j*N+i)*CW +: CW]), Q));
              r_q[j][i]  <= CW'(s2res(32'($signed(r_in[(j*N+i)*EW +: EW])), Q));
              e1_q[j][i] <= CW'(s2res(32'($signed(e1_in[(j*N+i)*EW +: EW])), Q));
              for (int c = 0; c < K; c++)
                a_q[j][c][i] <= CW'(mod_q(32'(a_in[((j*K+c)*N+i)*CW +: CW]), Q));
            end
          for (int i = 0; i < N; i++)
            e2_q[i] <= CW'(s2res(32'($signed(e2_in[i*EW +: EW])), Q));
          for (int r = 0; r <= K; r++)
            for (int i = 0; i < N; i++) acc_q[r][i] <= '0;
        end
        ST_MAC: acc_q[ro_q][d_idx] <= mac_res;
        ST_FINAL: begin
          for (int j = 0; j < K; j++)
            for (int i = 0; i < N; i++)
              u_q[(j*N+i)*CW +: CW] <=
                CW'(mod_q(32'(acc_q[j][i]) + 32'(e1_q[j][i]), Q));
          for (int i = 0; i < N; i++)
            v_q[i*CW +: CW] <=
              CW'(mod_q(32'(acc_q[K][i]) + 32'(e2_q[i]) +
                        (msg_q[i] ? qhalf(Q) : 32'd0), Q));
        end
        default: ;
      endcase
    end
  end

  assign busy  = (state_q != ST_IDLE);
  assign done  = done_q;
  assign u_out = u_q;
  assign v_out = v_q;

endmodule

// File: tb/tb_kyber_encrypt_seq.sv
// Scoreboard bench for kyber_encrypt_seq: directed vectors plus random back-to-back runs
// against a negacyclic polynomial-arithmetic reference model.
module tb_kyber_encrypt_seq;

  localparam int K   = 2;
  localparam int N   = 4;
  localparam int Q   = 17;
  localparam int CW  = 5;
  localparam int EW  = 4;
  localparam int LAT = (K+1)*K*N*N + 2;
  localparam int QH  = (Q+1)/2;

  typedef int poly_t [N];
  typedef struct {
    logic [K*N*CW-1:0] u;
    logic [N*CW-1:0]   v;
    int                cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic [K*K*N*CW-1:0] a_in  = '0;
  logic [K*N*CW-1:0]   t_in  = '0;
  logic [K*N*EW-1:0]   r_in  = '0;
  logic [K*N*EW-1:0]   e1_in = '0;
  logic [N*EW-1:0]     e2_in = '0;
  logic [N-1:0]        msg   = '0;
  logic [K*N*CW-1:0]   u_out;
  logic [N*CW-1:0]     v_out;

  kyber_encrypt_seq #(.K(K), .N(N), .Q(Q), .CW(CW), .EW(EW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .a_in(a_in), .t_in(t_in), .r_in(r_in), .e1_in(e1_in), .e2_in(e2_in),
    .msg(msg), .u_out(u_out), .v_out(v_out)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  exp_t  sb[$];
  int    n_vec = 0;
  int    n_err = 0;
  poly_t A [K][K];
  poly_t T [K];
  poly_t R [K];
  poly_t E1[K];
  poly_t E2;
  int    M [N];

  function automatic int md(input int x);
    int m;
    m = x % Q;
    return (m < 0) ? m + Q : m;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic clear_all();
    for (int j = 0; j < K; j++)
      for (int i = 0; i < N; i++) begin
        T[j][i] = 0; R[j][i] = 0; E1[j][i] = 0;
        for (int c = 0; c < K; c++) A[j][c][i] = 0;
      end
    for (int i = 0; i < N; i++) begin E2[i] = 0; M[i] = 0; end
  endtask

  task automatic rand_all();
    for (int j = 0; j < K; j++)
      for (int i = 0; i < N; i++) begin
        T[j][i]  = int'($urandom_range(0, 31));
        R[j][i]  = int'($urandom_range(0, 15)) - 8;
        E1[j][i] = int'($urandom_range(0, 15)) - 8;
        for (int c = 0; c < K; c++) A[j][c][i] = int'($urandom_range(0, 31));
      end
    for (int i = 0; i < N; i++) begin
      E2[i] = int'($urandom_range(0, 15)) - 8;
      M[i]  = int'($urandom_range(0, 1));
    end
  endtask

  task automatic drive();
    for (int j = 0; j < K; j++)
      for (int i = 0; i < N; i++) begin
        t_in[(j*N+i)*CW +: CW]  = CW'(T[j][i]);
        r_in[(j*N+i)*EW +: EW]  = EW'(R[j][i]);
        e1_in[(j*N+i)*EW +: EW] = EW'(E1[j][i]);
        for (int c = 0; c < K; c++) a_in[((j*K+c)*N+i)*CW +: CW] = CW'(A[j][c][i]);
      end
    for (int i = 0; i < N; i++) begin
      e2_in[i*EW +: EW] = EW'(E2[i]);
      msg[i] = (M[i] != 0);
    end
  endtask

  // Product in Z[x]/(x^N+1): x^N folds back as -1.
  task automatic nmul(input poly_t a, input poly_t b, output poly_t c);
    for (int i = 0; i < N; i++) c[i] = 0;
    for (int i = 0; i < N; i++)
      for (int k = 0; k < N; k++)
        if (i + k < N) c[i+k]   = c[i+k]   + a[i]*b[k];
        else           c[i+k-N] = c[i+k-N] - a[i]*b[k];
  endtask

  task automatic model(output logic [K*N*CW-1:0] eu, output logic [N*CW-1:0] ev);
    poly_t s, p;
    for (int c = 0; c < K; c++) begin
      for (int i = 0; i < N; i++) s[i] = 0;
      for (int j = 0; j < K; j++) begin
        nmul(A[j][c], R[j], p);
        for (int i = 0; i < N; i++) s[i] += p[i];
      end
      for (int i = 0; i < N; i++) eu[(c*N+i)*CW +: CW] = CW'(md(s[i] + E1[c][i]));
    end
    for (int i = 0; i < N; i++) s[i] = 0;
    for (int j = 0; j < K; j++) begin
      nmul(T[j], R[j], p);
      for (int i = 0; i < N; i++) s[i] += p[i];
    end
    for (int i = 0; i < N; i++)
      ev[i*CW +: CW] = CW'(md(s[i] + E2[i] + (M[i] != 0 ? QH : 0)));
  endtask

  // Called on a negedge; returns on the negedge where done is high.
  task automatic go(input logic [K*N*CW-1:0] eu, input logic [N*CW-1:0] ev);
    exp_t e;
    int   t;
    e.u = eu; e.v = ev; e.cyc = cyc + LAT + 1;
    sb.push_back(e);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 64'd1);
    t = 0;
    while (!done && t < LAT + 20) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", 64'(done), 64'd1);
    if (!done) sb.delete();
  endtask

  task automatic stimulus();
    logic [K*N*CW-1:0] eu;
    logic [N*CW-1:0]   ev;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_u", 64'(u_out), 64'd0);
    chk("rst_v", 64'(v_out), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    clear_all(); M[0] = 1; M[2] = 1; drive();
    eu = '0; ev = '0; ev[0*CW +: CW] = CW'(9); ev[2*CW +: CW] = CW'(9);
    go(eu, ev);

    clear_all(); T[0][3] = 1; R[0][1] = 1; drive();
    eu = '0; ev = '0; ev[0*CW +: CW] = CW'(16);
    go(eu, ev);

    clear_all(); A[0][1][0] = 1; R[0][0] = 1; drive();
    eu = '0; ev = '0; eu[(1*N+0)*CW +: CW] = CW'(1);
    go(eu, ev);

    clear_all();
    for (int j = 0; j < K; j++) for (int i = 0; i < N; i++) E1[j][i] = -1;
    for (int i = 0; i < N; i++) E2[i] = -3;
    drive();
    for (int x = 0; x < K*N; x++) eu[x*CW +: CW] = CW'(16);
    for (int x = 0; x < N; x++)   ev[x*CW +: CW] = CW'(14);
    go(eu, ev);

    for (int n = 0; n < 200; n++) begin
      if (n == 100) begin
        rand_all(); drive();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (41) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_u", 64'(u_out), 64'd0);
        chk("abort_v", 64'(v_out), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
      end
      rand_all(); drive(); model(eu, ev);
      go(eu, ev);
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && done) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 64'(done), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("u_out", 64'(u_out), 64'(e.u));
          chk("v_out", 64'(v_out), 64'(e.v));
          chk("done_cycle", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  endtask

  initial begin
    fork
      monitor();
      stimulus();
    join_any
    disable fork;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
